// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse character sequencer:
//   - state_t        : sequencer FSM states
//   - CODE_WORD_SPACE: char_code value meaning "word space"
//   - DUR_*          : duration selectors, in Morse units, for morse_unit_timer
//   - morse_entry_t  : one code table entry {len, sym}
//   - morse_lookup() : A..Z -> {len, sym}
// Symbols are left-aligned in sym: bit 3 is the first symbol sent, 1 = dash.
// -----------------------------------------------------------------------------
package morse_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MARK,
      SYM_GAP,
      CHAR_GAP,
      WORD_GAP
   } state_t;

   localparam logic [4:0] CODE_WORD_SPACE = 5'd26;

   localparam logic [2:0] DUR_1U = 3'd1;
   localparam logic [2:0] DUR_3U = 3'd3;
   localparam logic [2:0] DUR_7U = 3'd7;

   typedef struct packed {
      logic [2:0] len;   // number of symbols, 1..4
      logic [3:0] sym;   // left-aligned, MSB first, 1 = dash
   } morse_entry_t;

   function automatic morse_entry_t morse_lookup(input logic [4:0] code);
      morse_entry_t e;
      case (code)
         5'd0:    e = {3'd2, 4'b0100};  // A .-
         5'd1:    e = {3'd4, 4'b1000};  // B -...
         5'd2:    e = {3'd4, 4'b1010};  // C -.-.
         5'd3:    e = {3'd3, 4'b1000};  // D -..
         5'd4:    e = {3'd1, 4'b0000};  // E .
         5'd5:    e = {3'd4, 4'b0010};  // F ..-.
         5'd6:    e = {3'd3, 4'b1100};  // G --.
         5'd7:    e = {3'd4, 4'b0000};  // H ....
         5'd8:    e = {3'd2, 4'b0000};  // I ..
         5'd9:    e = {3'd4, 4'b0111};  // J .---
         5'd10:   e = {3'd3, 4'b1010};  // K -.-
         5'd11:   e = {3'd4, 4'b0100};  // L .-..
         5'd12:   e = {3'd2, 4'b1100};  // M --
         5'd13:   e = {3'd2, 4'b1000};  // N -.
         5'd14:   e = {3'd3, 4'b1110};  // O ---
         5'd15:   e = {3'd4, 4'b0110};  // P .--.
         5'd16:   e = {3'd4, 4'b1101};  // Q --.-
         5'd17:   e = {3'd3, 4'b0100};  // R .-.
         5'd18:   e = {3'd3, 4'b0000};  // S ...
         5'd19:   e = {3'd1, 4'b1000};  // T -
         5'd20:   e = {3'd3, 4'b0010};  // U ..-
         5'd21:   e = {3'd4, 4'b0001};  // V ...-
         5'd22:   e = {3'd3, 4'b0110};  // W .--
         5'd23:   e = {3'd4, 4'b1001};  // X -..-
         5'd24:   e = {3'd4, 4'b1011};  // Y -.--
         5'd25:   e = {3'd4, 4'b1100};  // Z --..
         default: e = {3'd0, 4'b0000};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/morse_char_sequencer_if.sv
// -----------------------------------------------------------------------------
// morse_char_sequencer_if
// Character input channel (valid/ready) of the Morse sequencer.
//   char_valid : source -> sequencer, char_code is valid this cycle
//   char_code  : source -> sequencer, 0..25 = A..Z, 26 = word space, else invalid
//   char_ready : sequencer -> source, a transfer happens when valid && ready
// Modports: master = character source, slave = sequencer.
// -----------------------------------------------------------------------------
interface morse_char_sequencer_if;

   logic       char_valid;
   logic [4:0] char_code;
   logic       char_ready;

   modport master (
      output char_valid,
      output char_code,
      input  char_ready
   );

   modport slave (
      input  char_valid,
      input  char_code,
      output char_ready
   );

endinterface

// File: rtl/morse_unit_timer.sv
// -----------------------------------------------------------------------------
// morse_unit_timer
// Loadable down-counter measuring a duration of 1, 3 or 7 Morse units.
// Ports:
//   clk          in  clock
//   rst_n        in  asynchronous active-low reset
//   i_load       in  start a new duration (takes priority over a running one)
//   i_dur_units  in  duration in units: 1, 3 or 7 (others treated as 1)
//   o_done       out one-cycle pulse during the last cycle of the duration
// After a load at edge T, o_done is high in the cycle ending at edge
// T + dur_units*UNIT_CYCLES, so a state entered at T lasts exactly that long.
// -----------------------------------------------------------------------------
module morse_unit_timer
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 12_500_000
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_load,
   input  logic [2:0] i_dur_units,
   output logic       o_done
);

   localparam int CNT_W = $clog2(7 * UNIT_CYCLES);

   // Terminal counts precomputed so no multiplier sits in the datapath.
   localparam logic [CNT_W-1:0] LIM_1U = CNT_W'(UNIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LIM_3U = CNT_W'(3 * UNIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LIM_7U = CNT_W'(7 * UNIT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_active;
   logic [CNT_W-1:0] w_load_val;

   always_comb begin
      w_load_val = LIM_1U;
      case (i_dur_units)
         DUR_3U:  w_load_val = LIM_3U;
         DUR_7U:  w_load_val = LIM_7U;
         default: w_load_val = LIM_1U;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_active <= 1'b0;
      end else if (i_load) begin
         r_cnt    <= w_load_val;
         r_active <= 1'b1;
      end else if (r_active) begin
         if (r_cnt == '0) begin
            r_active <= 1'b0;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   // r_active keeps the idle zero count from looking like a terminal count.
   assign o_done = r_active && (r_cnt == '0);

endmodule

// File: rtl/morse_char_sequencer.sv
// -----------------------------------------------------------------------------
// morse_char_sequencer
// Accepts one character per handshake, looks up its Morse code and blinks the
// LED with standard unit timing (dot 1U, dash 3U, symbol gap 1U, character
// gap 3U, word gap 7U).
// Ports:
//   clk      in   clock, single domain
//   rst_n    in   asynchronous active-low reset
//   char_if  slave character channel (char_valid, char_code, char_ready)
//   led      out  registered LED drive, 1 = on
//   busy     out  registered, high in every state except IDLE
//   err      out  registered one-cycle pulse when an invalid code is accepted
// -----------------------------------------------------------------------------
module morse_char_sequencer
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 12_500_000
)(
   input  logic                   clk,
   input  logic                   rst_n,
   morse_char_sequencer_if.slave  char_if,
   output logic                   led,
   output logic                   busy,
   output logic                   err
);

   state_t       r_state;
   state_t       w_state_next;
   logic [2:0]   r_len;
   logic [2:0]   w_len_next;
   logic [3:0]   r_sym;
   logic [3:0]   w_sym_next;
   logic [1:0]   r_idx;
   logic [1:0]   w_idx_next;
   logic         r_led;
   logic         r_busy;
   logic         r_err;
   logic         w_err_next;
   logic         w_load;
   logic [2:0]   w_dur;
   logic         w_done;
   logic         w_transfer;
   logic         w_last_sym;
   morse_entry_t w_entry;

   morse_unit_timer #(
      .UNIT_CYCLES (UNIT_CYCLES)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_load),
      .i_dur_units (w_dur),
      .o_done      (w_done)
   );

   assign char_if.char_ready = (r_state == IDLE);
   assign w_transfer         = char_if.char_valid && char_if.char_ready;
   assign w_entry            = morse_lookup(char_if.char_code);
   assign w_last_sym         = ({1'b0, r_idx} == (r_len - 3'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_len   <= '0;
         r_sym   <= '0;
         r_idx   <= '0;
         r_led   <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_len   <= w_len_next;
         r_sym   <= w_sym_next;
         r_idx   <= w_idx_next;
         // Outputs follow the state being entered, so they change only on
         // state entry and appear right after the transfer edge.
         r_led   <= (w_state_next == MARK);
         r_busy  <= (w_state_next != IDLE);
         r_err   <= w_err_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_len_next   = r_len;
      w_sym_next   = r_sym;
      w_idx_next   = r_idx;
      w_err_next   = 1'b0;
      w_load       = 1'b0;
      w_dur        = DUR_1U;

      case (r_state)
         IDLE: begin
            if (w_transfer) begin
               if (char_if.char_code < CODE_WORD_SPACE) begin
                  w_state_next = MARK;
                  w_len_next   = w_entry.len;
                  w_sym_next   = w_entry.sym;
                  w_idx_next   = 2'd0;
                  w_load       = 1'b1;
                  w_dur        = w_entry.sym[3] ? DUR_3U : DUR_1U;
               end else if (char_if.char_code == CODE_WORD_SPACE) begin
                  w_state_next = WORD_GAP;
                  w_load       = 1'b1;
                  w_dur        = DUR_7U;
               end else begin
                  // Invalid code: consumed and dropped, flagged for one cycle.
                  w_err_next = 1'b1;
               end
            end
         end

         MARK: begin
            if (w_done) begin
               w_load = 1'b1;
               if (w_last_sym) begin
                  w_state_next = CHAR_GAP;
                  w_dur        = DUR_3U;
               end else begin
                  // Shift now so bit 3 already holds the next symbol when the
                  // symbol gap ends and the next mark's length is chosen.
                  w_state_next = SYM_GAP;
                  w_dur        = DUR_1U;
                  w_sym_next   = {r_sym[2:0], 1'b0};
               end
            end
         end

         SYM_GAP: begin
            if (w_done) begin
               w_state_next = MARK;
               w_load       = 1'b1;
               w_dur        = r_sym[3] ? DUR_3U : DUR_1U;
               w_idx_next   = r_idx + 2'd1;
            end
         end

         CHAR_GAP, WORD_GAP: begin
            if (w_done) begin
               w_state_next = IDLE;
            end
         end

         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   assign led  = r_led;
   assign busy = r_busy;
   assign err  = r_err;

endmodule

// File: tb/tb_morse_char_sequencer.sv
// -----------------------------------------------------------------------------
// tb_morse_char_sequencer
// Directed bench for morse_char_sequencer with UNIT_CYCLES = 4. A model built
// from dot/dash strings predicts led/busy/err/char_ready for every cycle; a
// compare process checks them on each falling edge. Directed tests measure
// busy and lit-cycle counts against hand-computed totals.
// -----------------------------------------------------------------------------
module tb_morse_char_sequencer;

   localparam int U = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic led;
   logic busy;
   logic err;

   always #5 clk = ~clk;

   morse_char_sequencer_if cif ();

   morse_char_sequencer #(
      .UNIT_CYCLES (U)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .char_if (cif),
      .led     (led),
      .busy    (busy),
      .err     (err)
   );

   string morse_tab [26] = '{
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
      "..-", "...-", ".--", "-..-", "-.--", "--.."
   };

   int checks = 0;
   int errors = 0;

   // Model: per-cycle expected {led, busy}, plus the current cycle's values.
   logic [1:0] exp_q [$];
   logic [1:0] cur = 2'b00;
   logic       cur_err = 1'b0;
   logic       was_idle;

   function automatic void push_char(input int code);
      string s;
      if (code == 26) begin
         for (int k = 0; k < 7 * U; k++) exp_q.push_back(2'b01);
      end else begin
         s = morse_tab[code];
         for (int i = 0; i < s.len(); i++) begin
            int n;
            n = (s[i] == "-") ? 3 * U : U;
            for (int k = 0; k < n; k++) exp_q.push_back(2'b11);
            n = (i == s.len() - 1) ? 3 * U : U;
            for (int k = 0; k < n; k++) exp_q.push_back(2'b01);
         end
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         cur     = 2'b00;
         cur_err = 1'b0;
      end else begin
         was_idle = !cur[0];
         cur_err  = 1'b0;
         if (was_idle && cif.char_valid) begin
            if (cif.char_code <= 5'd26) push_char(int'(cif.char_code));
            else cur_err = 1'b1;
         end
         cur = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
      end
   end

   always @(negedge clk) begin
      checks++;
      if (led !== cur[1] || busy !== cur[0] || err !== cur_err ||
          cif.char_ready !== !cur[0]) begin
         errors++;
         $display("FAIL cycle_compare t=%0t led=%b/%b busy=%b/%b err=%b/%b ready=%b/%b (got/need)",
                  $time, led, cur[1], busy, cur[0], err, cur_err, cif.char_ready, !cur[0]);
      end
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, need %0d", name, act, req);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic send(input int code);
      @(posedge clk); #1;
      cif.char_valid = 1'b1;
      cif.char_code  = code[4:0];
      @(posedge clk); #1;
      cif.char_valid = 1'b0;
   endtask

   task automatic measure(input bit toggle, output int nbusy, output int nled);
      bit ended;
      nbusy = 0;
      nled  = 0;
      ended = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (!busy) begin
            ended = 1'b1;
            break;
         end
         nbusy++;
         if (led) nled++;
         if (toggle) cif.char_code = 5'($urandom_range(0, 31));
      end
      if (!ended) begin
         checks++;
         errors++;
         $display("FAIL measure_timeout: busy still high after 300 cycles");
      end
   endtask

   task automatic run_char(input string name, input int code,
                           input int exp_busy, input int exp_led);
      int nb, nl;
      send(code);
      measure(1'b1, nb, nl);
      check({name, "_busy"}, nb, exp_busy);
      check({name, "_led"}, nl, exp_led);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, nl, sum, eb;
      string s;
      cif.char_valid = 1'b0;
      cif.char_code  = 5'd0;

      // Pin the model against hand-computed totals.
      push_char(4);  check("model_E_len", exp_q.size(), 16);  exp_q.delete();
      push_char(18); check("model_S_len", exp_q.size(), 32);  exp_q.delete();
      push_char(14); check("model_O_len", exp_q.size(), 56);  exp_q.delete();
      push_char(26); check("model_ws_len", exp_q.size(), 28); exp_q.delete();

      #3;
      check("rst_led", int'(led), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_err", int'(err), 0);
      check("rst_ready", int'(cif.char_ready), 1);
      #19 rst_n = 1'b1;

      // T1, T2
      run_char("E", 4, 16, 4);
      run_char("S", 18, 32, 12);

      // T3: O then S with char_valid held; one idle cycle between them.
      @(posedge clk); #1;
      cif.char_valid = 1'b1;
      cif.char_code  = 5'd14;
      @(posedge clk); #1;
      cif.char_code  = 5'd18;
      measure(1'b0, nb, nl);
      check("O_busy", nb, 56);
      check("O_led", nl, 36);
      @(posedge clk); #1;
      cif.char_valid = 1'b0;
      measure(1'b1, nb, nl);
      check("O_S_next_busy", nb, 32);
      check("O_S_next_led", nl, 12);

      // T4: word space, then an invalid code.
      run_char("word", 26, 28, 0);
      send(30);
      @(negedge clk);
      check("inv_err", int'(err), 1);
      check("inv_busy", int'(busy), 0);
      check("inv_led", int'(led), 0);
      check("inv_ready", int'(cif.char_ready), 1);
      @(negedge clk);
      check("inv_err_cleared", int'(err), 0);

      // T5: reset during the second dash of O.
      send(14);
      repeat (20) @(negedge clk);
      check("pre_rst_led", int'(led), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_led", int'(led), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_ready", int'(cif.char_ready), 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      run_char("T", 19, 24, 12);

      // T6: whole alphabet against the dot/dash table.
      for (int c = 0; c < 26; c++) begin
         s   = morse_tab[c];
         sum = 0;
         for (int i = 0; i < s.len(); i++) sum += (s[i] == "-") ? 3 * U : U;
         eb = sum + (s.len() - 1) * U + 3 * U;
         run_char($sformatf("letter%0d", c), c, eb, sum);
      end

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
